mem_crc_scrubber: RTL and testbench
===================================

# mem_crc_scrubber

Controller in front of the CRC-protected register memory. It accepts host writes and attaches a CRC to each data word before the write reaches the array. In idle cycles it also runs a periodic background scrub: it reads each location, recomputes the CRC of the stored data and compares it with the stored CRC. Mismatches are reported as error events and counted; this is the FuSa latent-fault detection path for the memory.

## Interface
Parameters:
- DATA_WIDTH, 8, data word width; must match the memory.
- POLYNOMIAL_BITS, 8, CRC width; must match the memory.
- ADDR_WIDTH, 8, address width; depth is 2**ADDR_WIDTH.
- POLY, 8'h07, CRC generator polynomial without the implicit top bit, POLYNOMIAL_BITS wide.
- SCRUB_INTERVAL, 16, idle cycles between scrub reads; minimum 2.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- host_wr_valid  in  1  host write request
- host_wr_ready  out  1  write accepted when valid && ready
- host_wr_addr  in  ADDR_WIDTH  write address
- host_wr_data  in  DATA_WIDTH  write data
- inj_crc_flip  in  1  fault injection: invert bit 0 of the CRC written with this beat
- scrub_en  in  1  enables background scrubbing
- mem_wr  out  1  memory write strobe
- mem_addr  out  ADDR_WIDTH  memory address (write and read)
- mem_data_in  out  DATA_WIDTH  data to memory
- crc_data_in  out  POLYNOMIAL_BITS  CRC to memory
- mem_data_out  in  DATA_WIDTH  memory read data, combinational from mem_addr
- crc_data_out  in  POLYNOMIAL_BITS  stored CRC, combinational from mem_addr
- err_valid  out  1  one-cycle pulse on a scrub mismatch
- err_addr  out  ADDR_WIDTH  address of the last mismatch; holds between events
- err_count  out  16  saturating mismatch count
- pass_done  out  1  one-cycle pulse when the scrub pointer wraps to 0

## Operation
- CRC definition: no init value (zero), MSB-first, no reflection, no output XOR. Computed over one data word.
- States: IDLE, SCRUB_RD, SCRUB_CHK.
- Address mux:
  - SCRUB_RD: mem_addr = scrub_ptr.
  - Otherwise: mem_addr = host_wr_addr.
- host_wr_ready = (state != SCRUB_RD).
- Accepted write drives, in the same cycle (combinational):
  - mem_wr = 1
  - mem_data_in = host_wr_data
  - crc_data_in = crc(host_wr_data) ^ {0…, inj_crc_flip}
- Interval counter:
  - Increments while scrub_en && state == IDLE && !pending.
  - At SCRUB_INTERVAL-1 it sets pending and clears to 0.
- Scrub sequence:
  - IDLE && pending → SCRUB_RD. A host write in that IDLE cycle is still accepted.
  - SCRUB_RD: register mem_data_out and crc_data_out; clear pending → SCRUB_CHK.
  - SCRUB_CHK: compare crc(registered data) against the registered CRC; increment scrub_ptr → IDLE. Host writes are allowed in this cycle.
  - On mismatch in SCRUB_CHK, at the next edge: err_valid = 1, err_addr = checked address, err_count += 1 saturating at 16'hFFFF.
- scrub_ptr wraps from 2**ADDR_WIDTH-1 to 0; pass_done pulses on the same edge the wrap occurs.
- scrub_en = 0: counter and pending are cleared. A scrub already in SCRUB_RD or SCRUB_CHK completes. scrub_ptr holds.
- Host write to the address being checked during SCRUB_CHK: the check uses the content sampled in SCRUB_RD. The new data does not affect the result.

## Timing
- Reset values:
  - Outputs: mem_wr = 0, mem_addr = host_wr_addr (combinational), mem_data_in and crc_data_in are don't-care with mem_wr = 0, host_wr_ready = 1, err_valid = 0, err_addr = 0, err_count = 0, pass_done = 0.
  - Internal: state IDLE, scrub_ptr = 0, counter = 0, pending = 0.
- Write latency: zero cycles from accept to mem_wr. The memory updates on the same edge.
- Scrub read to err_valid: 2 edges (SCRUB_RD edge, then SCRUB_CHK edge).
- Scrub period with no stall: SCRUB_INTERVAL + 2 cycles per address.
- Reset asserted mid-scrub: aborts immediately, no err_valid, all state returns to reset values.

## Structure
- Package mem_crc_pkg holds:
  - State enum scrub_state_t.
  - Parameterised CRC function crc_calc (data, POLY).
  - ERR_CNT_W = 16.
- Sub-module crc_gen: combinational, width- and polynomial-parameterised. Instanced twice: write path and check path.
- The FSM, counter, pointer and error registers live in the top module. No memory inside this block.

## Test plan
- Write path: with scrub_en = 0, write addr 0x05 / data 0x01, then addr 0x06 / data 0xFF, then addr 0x07 / data 0x80 -> crc_data_in = 0x07, 0xF3, 0x89 respectively, mem_wr high exactly one cycle each.
- Clean scrub: fill all 256 locations via the block, set scrub_en = 1 -> pass_done after 256 × 18 cycles, err_valid never asserted, err_count = 0.
- Fault injection: write 0x3C to addr 0x10 with inj_crc_flip = 1, then scrub -> a single err_valid with err_addr = 0x10, err_count = 1. Rewrite with inj_crc_flip = 0 -> the next pass reports no error.
- Contention: hold host_wr_valid continuously during a scrub -> host_wr_ready is low only in the SCRUB_RD cycle, no write lost, mem_addr = scrub_ptr in that cycle.
- Same-address race: corrupt addr 0x20, then during SCRUB_CHK of 0x20 issue a clean host write to 0x20 -> err_valid is still reported for 0x20, and the next pass is clean.
- Reset mid-scrub: assert rst_n low in SCRUB_RD -> err_valid stays 0, err_count = 0, scrub_ptr = 0, host_wr_ready = 1 during reset.

Source files
------------

// File: rtl/mem_crc_pkg.sv
// Shared state type, constants and the bit-serial CRC helper used by the
// CRC-protected memory scrubber.
package mem_crc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCRUB_RD,
        SCRUB_CHK
    } scrub_state_t;

    localparam int ERR_CNT_W  = 16;
    localparam int DATA_MAX_W = 32;
    localparam int CRC_MAX_W  = 32;

    // Zero-init, MSB-first, unreflected CRC. Callers pass zero-extended
    // operands plus their real widths. Bits above crc_w are cleared on return.
    function automatic logic [CRC_MAX_W-1:0] crc_calc(
        input logic [DATA_MAX_W-1:0] data,
        input logic [CRC_MAX_W-1:0]  poly,
        input int                    data_w,
        input int                    crc_w
    );
        logic [CRC_MAX_W-1:0] crc;
        logic                 fb;
        crc = '0;
        for (int i = DATA_MAX_W - 1; i >= 0; i--) begin
            if (i < data_w) begin
                fb  = crc[crc_w-1] ^ data[i];
                crc = crc << 1;
                if (fb) begin
                    crc = crc ^ poly;
                end
            end
        end
        for (int j = 0; j < CRC_MAX_W; j++) begin
            if (j >= crc_w) begin
                crc[j] = 1'b0;
            end
        end
        return crc;
    endfunction

endpackage

// File: rtl/crc_gen.sv
// Combinational CRC generator over one data word, parameterised in data width,
// CRC width and generator polynomial.
module crc_gen
    import mem_crc_pkg::*;
#(
    parameter int                   DATA_WIDTH = 8,
    parameter int                   CRC_WIDTH  = 8,
    parameter logic [CRC_WIDTH-1:0] POLY       = 8'h07
) (
    input  logic [DATA_WIDTH-1:0] data,
    output logic [CRC_WIDTH-1:0]  crc
);

    assign crc = CRC_WIDTH'(crc_calc(DATA_MAX_W'(data), CRC_MAX_W'(POLY),
                                     DATA_WIDTH, CRC_WIDTH));

endmodule

// File: rtl/mem_crc_scrubber.sv
// Write-path CRC attach plus periodic background scrub of the CRC-protected
// register memory. Scrub mismatches are reported and counted.
module mem_crc_scrubber
    import mem_crc_pkg::*;
#(
    parameter int                         DATA_WIDTH      = 8,
    parameter int                         POLYNOMIAL_BITS = 8,
    parameter int                         ADDR_WIDTH      = 8,
    parameter logic [POLYNOMIAL_BITS-1:0] POLY            = 8'h07,
    parameter int                         SCRUB_INTERVAL  = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       host_wr_valid,
    output logic                       host_wr_ready,
    input  logic [ADDR_WIDTH-1:0]      host_wr_addr,
    input  logic [DATA_WIDTH-1:0]      host_wr_data,
    input  logic                       inj_crc_flip,
    input  logic                       scrub_en,
    output logic                       mem_wr,
    output logic [ADDR_WIDTH-1:0]      mem_addr,
    output logic [DATA_WIDTH-1:0]      mem_data_in,
    output logic [POLYNOMIAL_BITS-1:0] crc_data_in,
    input  logic [DATA_WIDTH-1:0]      mem_data_out,
    input  logic [POLYNOMIAL_BITS-1:0] crc_data_out,
    output logic                       err_valid,
    output logic [ADDR_WIDTH-1:0]      err_addr,
    output logic [ERR_CNT_W-1:0]       err_count,
    output logic                       pass_done
);

    localparam int                CNT_W    = $clog2(SCRUB_INTERVAL);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCRUB_INTERVAL - 2);

    scrub_state_t                 state_q, state_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic                         pending_q, pending_d;
    logic [ADDR_WIDTH-1:0]        scrub_ptr_q, scrub_ptr_d;
    logic [DATA_WIDTH-1:0]        rd_data_q, rd_data_d;
    logic [POLYNOMIAL_BITS-1:0]   rd_crc_q, rd_crc_d;
    logic                         err_valid_q, err_valid_d;
    logic [ADDR_WIDTH-1:0]        err_addr_q, err_addr_d;
    logic [ERR_CNT_W-1:0]         err_count_q, err_count_d;
    logic                         pass_done_q, pass_done_d;
    logic [POLYNOMIAL_BITS-1:0]   wr_crc;
    logic [POLYNOMIAL_BITS-1:0]   chk_crc;

    crc_gen #(
        .DATA_WIDTH (DATA_WIDTH),
        .CRC_WIDTH  (POLYNOMIAL_BITS),
        .POLY       (POLY)
    ) u_wr_crc (
        .data (host_wr_data),
        .crc  (wr_crc)
    );

    crc_gen #(
        .DATA_WIDTH (DATA_WIDTH),
        .CRC_WIDTH  (POLYNOMIAL_BITS),
        .POLY       (POLY)
    ) u_chk_crc (
        .data (rd_data_q),
        .crc  (chk_crc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A pending scrub only starts while scrubbing is still enabled; once in
    // SCRUB_RD the read/check pair always runs to completion.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (pending_q && scrub_en) state_d = SCRUB_RD;
            SCRUB_RD:  state_d = SCRUB_CHK;
            SCRUB_CHK: state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        host_wr_ready = (state_q != SCRUB_RD);
        mem_wr        = host_wr_valid && host_wr_ready;
        mem_addr      = (state_q == SCRUB_RD) ? scrub_ptr_q : host_wr_addr;
        mem_data_in   = host_wr_data;
        crc_data_in   = wr_crc ^ POLYNOMIAL_BITS'(inj_crc_flip);
    end

    // The pending cycle counts as the last idle cycle, so one address is
    // checked every SCRUB_INTERVAL + 2 cycles.
    always_comb begin
        cnt_d       = cnt_q;
        pending_d   = pending_q;
        scrub_ptr_d = scrub_ptr_q;
        rd_data_d   = rd_data_q;
        rd_crc_d    = rd_crc_q;
        err_valid_d = 1'b0;
        err_addr_d  = err_addr_q;
        err_count_d = err_count_q;
        pass_done_d = 1'b0;

        if (!scrub_en) begin
            cnt_d     = '0;
            pending_d = 1'b0;
        end else if (state_q == SCRUB_RD) begin
            pending_d = 1'b0;
        end else if (state_q == IDLE && !pending_q) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d     = '0;
                pending_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        if (state_q == SCRUB_RD) begin
            rd_data_d = mem_data_out;
            rd_crc_d  = crc_data_out;
        end

        if (state_q == SCRUB_CHK) begin
            scrub_ptr_d = scrub_ptr_q + ADDR_WIDTH'(1);
            pass_done_d = (scrub_ptr_q == {ADDR_WIDTH{1'b1}});
            if (chk_crc != rd_crc_q) begin
                err_valid_d = 1'b1;
                err_addr_d  = scrub_ptr_q;
                if (err_count_q != {ERR_CNT_W{1'b1}}) begin
                    err_count_d = err_count_q + ERR_CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            pending_q   <= 1'b0;
            scrub_ptr_q <= '0;
            rd_data_q   <= '0;
            rd_crc_q    <= '0;
            err_valid_q <= 1'b0;
            err_addr_q  <= '0;
            err_count_q <= '0;
            pass_done_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            pending_q   <= pending_d;
            scrub_ptr_q <= scrub_ptr_d;
            rd_data_q   <= rd_data_d;
            rd_crc_q    <= rd_crc_d;
            err_valid_q <= err_valid_d;
            err_addr_q  <= err_addr_d;
            err_count_q <= err_count_d;
            pass_done_q <= pass_done_d;
        end
    end

    assign err_valid = err_valid_q;
    assign err_addr  = err_addr_q;
    assign err_count = err_count_q;
    assign pass_done = pass_done_q;

endmodule

// File: tb/tb_mem_crc_scrubber.sv
// Directed bench for mem_crc_scrubber with a 256-entry combinational-read
// memory model attached to the memory-side ports.
module tb_mem_crc_scrubber;

    localparam int PASS_CYCLES = 256 * 18;

    logic       clk;
    logic       rst_n;
    logic       host_wr_valid;
    logic       host_wr_ready;
    logic [7:0] host_wr_addr;
    logic [7:0] host_wr_data;
    logic       inj_crc_flip;
    logic       scrub_en;
    logic       mem_wr;
    logic [7:0] mem_addr;
    logic [7:0] mem_data_in;
    logic [7:0] crc_data_in;
    logic [7:0] mem_data_out;
    logic [7:0] crc_data_out;
    logic       err_valid;
    logic [7:0] err_addr;
    logic [15:0] err_count;
    logic       pass_done;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem_d [256];
    logic [7:0] mem_c [256];

    mem_crc_scrubber dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .host_wr_valid (host_wr_valid),
        .host_wr_ready (host_wr_ready),
        .host_wr_addr  (host_wr_addr),
        .host_wr_data  (host_wr_data),
        .inj_crc_flip  (inj_crc_flip),
        .scrub_en      (scrub_en),
        .mem_wr        (mem_wr),
        .mem_addr      (mem_addr),
        .mem_data_in   (mem_data_in),
        .crc_data_in   (crc_data_in),
        .mem_data_out  (mem_data_out),
        .crc_data_out  (crc_data_out),
        .err_valid     (err_valid),
        .err_addr      (err_addr),
        .err_count     (err_count),
        .pass_done     (pass_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_data_out = mem_d[mem_addr];
    assign crc_data_out = mem_c[mem_addr];

    always @(posedge clk) begin
        if (mem_wr) begin
            mem_d[mem_addr] <= mem_data_in;
            mem_c[mem_addr] <= crc_data_in;
        end
    end

    function automatic logic [7:0] crc8(input logic [7:0] d);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            c = (c[7] ^ d[i]) ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    task automatic write_word(input logic [7:0] a, input logic [7:0] d, input logic inj);
        @(negedge clk);
        host_wr_valid = 1'b1;
        host_wr_addr  = a;
        host_wr_data  = d;
        inj_crc_flip  = inj;
        @(posedge clk);
        #1;
        host_wr_valid = 1'b0;
        inj_crc_flip  = 1'b0;
    endtask

    task automatic stop_scrub();
        @(negedge clk);
        scrub_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_pass(output int cycles, output int nerr,
                            output logic [7:0] last_err, output bit timed_out);
        cycles    = 0;
        nerr      = 0;
        last_err  = 8'h00;
        timed_out = 1'b1;
        for (int i = 0; i < 6000; i++) begin
            @(posedge clk);
            #1;
            cycles++;
            if (err_valid === 1'b1) begin
                nerr++;
                last_err = err_addr;
            end
            if (pass_done === 1'b1) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        host_wr_valid = 1'b0;
        host_wr_addr  = 8'h5A;
        host_wr_data  = 8'h00;
        inj_crc_flip  = 1'b0;
        scrub_en      = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        checks++; if (host_wr_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %0b want 1", host_wr_ready); end
        checks++; if (mem_wr !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_wr: got %0b want 0", mem_wr); end
        checks++; if (mem_addr !== 8'h5A) begin errors++; $display("[TB] FAIL reset_mem_addr: got %h want 5a", mem_addr); end
        checks++; if (err_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_err_valid: got %0b want 0", err_valid); end
        checks++; if (err_addr !== 8'h00) begin errors++; $display("[TB] FAIL reset_err_addr: got %h want 00", err_addr); end
        checks++; if (err_count !== 16'h0000) begin errors++; $display("[TB] FAIL reset_err_count: got %h want 0000", err_count); end
        checks++; if (pass_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_pass_done: got %0b want 0", pass_done); end
        rst_n = 1'b1;
    endtask

    task automatic test_write_path();
        logic [7:0] wa [3];
        logic [7:0] wd [3];
        logic [7:0] wc [3];
        wa = '{8'h05, 8'h06, 8'h07};
        wd = '{8'h01, 8'hFF, 8'h80};
        wc = '{8'h07, 8'hF3, 8'h89};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            host_wr_valid = 1'b1;
            host_wr_addr  = wa[i];
            host_wr_data  = wd[i];
            #1;
            checks++; if (mem_wr !== 1'b1) begin errors++; $display("[TB] FAIL wr_strobe[%0d]: got %0b want 1", i, mem_wr); end
            checks++; if (crc_data_in !== wc[i]) begin errors++; $display("[TB] FAIL wr_crc[%0d]: got %h want %h", i, crc_data_in, wc[i]); end
            checks++; if (mem_data_in !== wd[i]) begin errors++; $display("[TB] FAIL wr_data[%0d]: got %h want %h", i, mem_data_in, wd[i]); end
            checks++; if (mem_addr !== wa[i]) begin errors++; $display("[TB] FAIL wr_addr[%0d]: got %h want %h", i, mem_addr, wa[i]); end
            @(negedge clk);
            host_wr_valid = 1'b0;
            #1;
            checks++; if (mem_wr !== 1'b0) begin errors++; $display("[TB] FAIL wr_strobe_off[%0d]: got %0b want 0", i, mem_wr); end
        end
    endtask

    task automatic test_clean_scrub();
        int cyc;
        int nerr;
        logic [7:0] last;
        bit to;
        for (int i = 0; i < 256; i++) begin
            write_word(8'(i), 8'(i) ^ 8'hA5, 1'b0);
        end
        @(negedge clk);
        scrub_en = 1'b1;
        run_pass(cyc, nerr, last, to);
        checks++; if (to) begin errors++; $display("[TB] FAIL clean_pass_timeout: no pass_done within bound"); end
        checks++; if (cyc != PASS_CYCLES) begin errors++; $display("[TB] FAIL clean_pass_cycles: got %0d want %0d", cyc, PASS_CYCLES); end
        checks++; if (nerr != 0) begin errors++; $display("[TB] FAIL clean_err_pulses: got %0d want 0", nerr); end
        checks++; if (err_count !== 16'h0000) begin errors++; $display("[TB] FAIL clean_err_count: got %h want 0000", err_count); end
        @(posedge clk);
        #1;
        checks++; if (pass_done !== 1'b0) begin errors++; $display("[TB] FAIL pass_done_width: got %0b want 0", pass_done); end
        stop_scrub();
    endtask

    task automatic test_fault_injection();
        int cyc;
        int nerr;
        logic [7:0] last;
        bit to;
        write_word(8'h10, 8'h3C, 1'b1);
        @(negedge clk);
        scrub_en = 1'b1;
        run_pass(cyc, nerr, last, to);
        checks++; if (to) begin errors++; $display("[TB] FAIL fault_pass_timeout: no pass_done within bound"); end
        checks++; if (nerr != 1) begin errors++; $display("[TB] FAIL fault_err_pulses: got %0d want 1", nerr); end
        checks++; if (last !== 8'h10) begin errors++; $display("[TB] FAIL fault_pulse_addr: got %h want 10", last); end
        checks++; if (err_addr !== 8'h10) begin errors++; $display("[TB] FAIL fault_err_addr_hold: got %h want 10", err_addr); end
        checks++; if (err_count !== 16'h0001) begin errors++; $display("[TB] FAIL fault_err_count: got %h want 0001", err_count); end
        stop_scrub();
        write_word(8'h10, 8'h3C, 1'b0);
        @(negedge clk);
        scrub_en = 1'b1;
        run_pass(cyc, nerr, last, to);
        checks++; if (to || cyc != PASS_CYCLES) begin errors++; $display("[TB] FAIL fault_rewrite_cycles: got %0d want %0d", cyc, PASS_CYCLES); end
        checks++; if (nerr != 0) begin errors++; $display("[TB] FAIL fault_rewrite_pulses: got %0d want 0", nerr); end
        checks++; if (err_count !== 16'h0001) begin errors++; $display("[TB] FAIL fault_rewrite_count: got %h want 0001", err_count); end
        stop_scrub();
    endtask

    task automatic test_contention();
        int k = 0;
        int rd_count = 0;
        logic [7:0] exp_ptr = 8'h00;
        bit prev_low = 1'b0;
        bit acc;
        logic [7:0] wa;
        logic [7:0] wd;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (i == 0) scrub_en = 1'b1;
            wa = 8'(8'h40 + k);
            wd = 8'(k * 7 + 1);
            host_wr_valid = 1'b1;
            host_wr_addr  = wa;
            host_wr_data  = wd;
            #1;
            if (prev_low) begin
                checks++; if (host_wr_ready !== 1'b1) begin errors++; $display("[TB] FAIL cont_ready_run[%0d]: got %0b want 1", i, host_wr_ready); end
            end
            if (host_wr_ready === 1'b0) begin
                checks++;
                if (mem_addr !== exp_ptr || mem_wr !== 1'b0) begin
                    errors++; $display("[TB] FAIL cont_rd_cycle[%0d]: addr %h wr %0b want addr %h wr 0", i, mem_addr, mem_wr, exp_ptr);
                end
                exp_ptr++;
                rd_count++;
                acc = 1'b0;
            end else begin
                checks++;
                if (mem_wr !== 1'b1 || mem_addr !== wa) begin
                    errors++; $display("[TB] FAIL cont_wr_cycle[%0d]: addr %h wr %0b want addr %h wr 1", i, mem_addr, mem_wr, wa);
                end
                acc = 1'b1;
            end
            prev_low = (host_wr_ready === 1'b0);
            @(posedge clk);
            if (acc) k++;
        end
        @(negedge clk);
        host_wr_valid = 1'b0;
        scrub_en      = 1'b0;
        @(negedge clk);
        checks++; if (rd_count != 3) begin errors++; $display("[TB] FAIL cont_rd_count: got %0d want 3", rd_count); end
        checks++; if (err_count !== 16'h0001) begin errors++; $display("[TB] FAIL cont_err_count: got %h want 0001", err_count); end
        for (int j = 0; j < k; j++) begin
            checks++;
            if (mem_d[8'(8'h40 + j)] !== 8'(j * 7 + 1) || mem_c[8'(8'h40 + j)] !== crc8(8'(j * 7 + 1))) begin
                errors++; $display("[TB] FAIL cont_store[%0d]: data %h crc %h want data %h crc %h", j,
                                   mem_d[8'(8'h40 + j)], mem_c[8'(8'h40 + j)], 8'(j * 7 + 1), crc8(8'(j * 7 + 1)));
            end
        end
    endtask

    task automatic test_same_addr_race();
        logic [7:0] exp_ptr = 8'h03;
        bit found = 1'b0;
        int cyc;
        int nerr;
        logic [7:0] last;
        bit to;
        write_word(8'h20, 8'h55, 1'b1);
        @(negedge clk);
        scrub_en = 1'b1;
        for (int i = 0; i < 1000 && !found; i++) begin
            @(negedge clk);
            #1;
            if (host_wr_ready === 1'b0) begin
                checks++; if (mem_addr !== exp_ptr) begin errors++; $display("[TB] FAIL race_scrub_addr: got %h want %h", mem_addr, exp_ptr); end
                if (exp_ptr == 8'h20) found = 1'b1;
                else exp_ptr++;
            end
        end
        checks++; if (!found) begin errors++; $display("[TB] FAIL race_reach_20: scrub of 20 not seen within bound"); end
        if (found) begin
            @(negedge clk);
            host_wr_valid = 1'b1;
            host_wr_addr  = 8'h20;
            host_wr_data  = 8'h55;
            inj_crc_flip  = 1'b0;
            #1;
            checks++; if (host_wr_ready !== 1'b1 || mem_wr !== 1'b1) begin errors++; $display("[TB] FAIL race_chk_write: ready %0b wr %0b want 1 1", host_wr_ready, mem_wr); end
            checks++; if (crc_data_in !== crc8(8'h55)) begin errors++; $display("[TB] FAIL race_wr_crc: got %h want %h", crc_data_in, crc8(8'h55)); end
            @(posedge clk);
            #1;
            host_wr_valid = 1'b0;
            checks++; if (err_valid !== 1'b1) begin errors++; $display("[TB] FAIL race_err_valid: got %0b want 1", err_valid); end
            checks++; if (err_addr !== 8'h20) begin errors++; $display("[TB] FAIL race_err_addr: got %h want 20", err_addr); end
            checks++; if (err_count !== 16'h0002) begin errors++; $display("[TB] FAIL race_err_count: got %h want 0002", err_count); end
            run_pass(cyc, nerr, last, to);
            checks++; if (to || nerr != 0) begin errors++; $display("[TB] FAIL race_rest_of_pass: pulses %0d timeout %0b want 0 0", nerr, to); end
            run_pass(cyc, nerr, last, to);
            checks++; if (to || cyc != PASS_CYCLES) begin errors++; $display("[TB] FAIL race_next_cycles: got %0d want %0d", cyc, PASS_CYCLES); end
            checks++; if (nerr != 0) begin errors++; $display("[TB] FAIL race_next_pulses: got %0d want 0", nerr); end
            checks++; if (err_count !== 16'h0002) begin errors++; $display("[TB] FAIL race_next_count: got %h want 0002", err_count); end
        end
        stop_scrub();
    endtask

    task automatic test_reset_mid_scrub();
        int rd_seen = 0;
        bit found = 1'b0;
        bit got = 1'b0;
        bit saw_err = 1'b0;
        int n = 0;
        write_word(8'h02, 8'h99, 1'b1);
        @(negedge clk);
        scrub_en = 1'b1;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            #1;
            if (host_wr_ready === 1'b0) begin
                if (rd_seen == 2) found = 1'b1;
                else rd_seen++;
            end
        end
        checks++; if (!found || mem_addr !== 8'h02) begin errors++; $display("[TB] FAIL rst_reach_rd: found %0b addr %h want 1 02", found, mem_addr); end
        if (found) begin
            rst_n = 1'b0;
            #1;
            checks++; if (host_wr_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_ready: got %0b want 1", host_wr_ready); end
            checks++; if (err_count !== 16'h0000) begin errors++; $display("[TB] FAIL rst_err_count: got %h want 0000", err_count); end
            checks++; if (err_addr !== 8'h00) begin errors++; $display("[TB] FAIL rst_err_addr: got %h want 00", err_addr); end
            @(posedge clk);
            #1;
            checks++; if (err_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_err_valid: got %0b want 0", err_valid); end
            @(negedge clk);
            rst_n = 1'b1;
            for (int i = 0; i < 40; i++) begin
                #1;
                if (err_valid !== 1'b0) saw_err = 1'b1;
                if (host_wr_ready === 1'b0) begin
                    got = 1'b1;
                    break;
                end
                @(negedge clk);
                n++;
            end
            checks++; if (!got || n != 16) begin errors++; $display("[TB] FAIL rst_first_rd_time: got %0d seen %0b want 16", n, got); end
            checks++; if (mem_addr !== 8'h00) begin errors++; $display("[TB] FAIL rst_scrub_ptr: got %h want 00", mem_addr); end
            checks++; if (saw_err) begin errors++; $display("[TB] FAIL rst_no_err_after: got 1 want 0"); end
        end
        stop_scrub();
    endtask

    initial begin
        test_reset();
        test_write_path();
        test_clean_scrub();
        test_fault_injection();
        test_contention();
        test_same_addr_race();
        test_reset_mid_scrub();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
